// File: rtl/apb_master_if.sv
// Bundle of the command, APB and response signals around the APB initiator.
// The master modport is the initiator's view; the slave modport is the view of
// whatever drives commands and plays the APB responder.
interface apb_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Command port
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [DATA_WIDTH/8-1:0] cmd_strobe;
  // APB request
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    trnsfr;
  // APB response
  logic                    pready;
  logic                    pslverr;
  logic [DATA_WIDTH-1:0]   prdata;
  // Response port
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;
  logic                    rsp_timeout;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strobe,
    output cmd_ready,
    output psel, penable, pwrite, paddr, pwdata, pstrb, trnsfr,
    input  pready, pslverr, prdata,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strobe,
    input  cmd_ready,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, trnsfr,
    output pready, pslverr, prdata,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout
  );
endinterface

// File: rtl/apb_master.sv
// APB initiator: takes one command at a time, runs the SETUP/ACCESS sequence,
// returns a one-cycle response and aborts a transfer whose responder keeps
// pready low for too long.
module apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic          clk,
  input logic          rst,
  apb_master_if.master bus
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    wait_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_W-1:0]   pstrb_q;
  logic                rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                rsp_err_q;
  logic                rsp_timeout_q;

  logic                accept;
  logic                tmo_hit;

  // A new command can be taken in IDLE, or in the completing ACCESS cycle for
  // back-to-back transfers; the abort cycle never accepts.
  assign bus.cmd_ready = (state_q == IDLE) | ((state_q == ACCESS) & bus.pready);
  assign bus.trnsfr    = (state_q == ACCESS) & bus.cmd_valid;
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  // Counter already at the limit and still no pready: this edge aborts.
  assign tmo_hit       = (TIMEOUT_CYCLES != 0) && (state_q == ACCESS) &&
                         !bus.pready && (wait_q == CNT_LIM);

  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

  // Transfer sequencer with registered APB and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wait_q        <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;

      // Payload is captured only on accept and otherwise held.
      if (accept) begin
        pwrite_q <= bus.cmd_write;
        paddr_q  <= bus.cmd_addr;
        pwdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
        pstrb_q  <= bus.cmd_strobe;
      end

      unique case (state_q)
        IDLE: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          if (accept) begin
            psel_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          // psel rose a cycle earlier, so penable may rise now.
          penable_q <= 1'b1;
          wait_q    <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus.pslverr;
            rsp_rdata_q <= (!pwrite_q && !bus.pslverr) ? bus.prdata : '0;
            wait_q      <= '0;
            penable_q   <= 1'b0;
            if (accept) begin
              state_q <= SETUP;
            end else begin
              psel_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (tmo_hit) begin
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            wait_q        <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= IDLE;
          end else if (wait_q != CNT_MAX) begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a four-cycle wait-state timeout.
module tb_apb_master;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  apb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    bus.cmd_valid  = v;
    bus.cmd_write  = w;
    bus.cmd_addr   = a;
    bus.cmd_wdata  = d;
    bus.cmd_strobe = s;
  endtask

  task automatic set_rsp(input logic r, input logic e, input logic [31:0] d);
    bus.pready  = r;
    bus.pslverr = e;
    bus.prdata  = d;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_rsp(1'b0, 1'b0, 32'h0);
    step();
    step();
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_trnsfr", bus.trnsfr, 0);
    rst = 1'b0;
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);

    // Zero-wait write
    set_cmd(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    set_rsp(1'b1, 1'b0, 32'h0);
    step();
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("w_setup_psel", bus.psel, 1);
    chk("w_setup_penable", bus.penable, 0);
    chk("w_setup_paddr", bus.paddr, 32'h10);
    chk("w_setup_pwdata", bus.pwdata, 32'hDEADBEEF);
    chk("w_setup_pwrite", bus.pwrite, 1);
    chk("w_setup_pstrb", bus.pstrb, 4'hF);
    chk("w_setup_cmd_ready", bus.cmd_ready, 0);
    step();
    chk("w_access_penable", bus.penable, 1);
    chk("w_access_rsp_valid", bus.rsp_valid, 0);
    chk("w_access_cmd_ready", bus.cmd_ready, 1);
    step();
    chk("w_rsp_valid", bus.rsp_valid, 1);
    chk("w_rsp_err", bus.rsp_err, 0);
    chk("w_rsp_rdata", bus.rsp_rdata, 0);
    chk("w_after_psel", bus.psel, 0);
    chk("w_after_paddr", bus.paddr, 32'h10);
    step();
    chk("w_rsp_pulse_end", bus.rsp_valid, 0);

    // Read with three wait states
    set_cmd(1'b1, 1'b0, 32'h20, 32'h55555555, 4'h3);
    set_rsp(1'b0, 1'b0, 32'hBAD0BAD0);
    step();
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("r_setup_pwdata", bus.pwdata, 0);
    chk("r_setup_pwrite", bus.pwrite, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) set_rsp(1'b1, 1'b0, 32'h12345678);
      chk("r_wait_penable", bus.penable, 1);
      chk("r_wait_paddr", bus.paddr, 32'h20);
      chk("r_wait_rsp_valid", bus.rsp_valid, 0);
    end
    step();
    chk("r_rsp_valid", bus.rsp_valid, 1);
    chk("r_rsp_rdata", bus.rsp_rdata, 32'h12345678);
    chk("r_rsp_err", bus.rsp_err, 0);
    chk("r_after_psel", bus.psel, 0);

    // Back-to-back write then read
    set_cmd(1'b1, 1'b1, 32'h30, 32'h11111111, 4'hF);
    set_rsp(1'b1, 1'b0, 32'hCAFEF00D);
    step();
    set_cmd(1'b1, 1'b0, 32'h40, 32'h22222222, 4'h1);
    #1;
    chk("b2b_p1_psel", bus.psel, 1);
    chk("b2b_p1_penable", bus.penable, 0);
    chk("b2b_p1_paddr", bus.paddr, 32'h30);
    step();
    chk("b2b_p2_penable", bus.penable, 1);
    chk("b2b_trnsfr", bus.trnsfr, 1);
    chk("b2b_cmd_ready", bus.cmd_ready, 1);
    step();
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("b2b_p3_psel", bus.psel, 1);
    chk("b2b_p3_penable", bus.penable, 0);
    chk("b2b_p3_paddr", bus.paddr, 32'h40);
    chk("b2b_p3_pwdata", bus.pwdata, 0);
    chk("b2b_rsp1_valid", bus.rsp_valid, 1);
    chk("b2b_rsp1_rdata", bus.rsp_rdata, 0);
    step();
    chk("b2b_p4_penable", bus.penable, 1);
    chk("b2b_p4_rsp_valid", bus.rsp_valid, 0);
    chk("b2b_p4_trnsfr", bus.trnsfr, 0);
    step();
    chk("b2b_rsp2_valid", bus.rsp_valid, 1);
    chk("b2b_rsp2_rdata", bus.rsp_rdata, 32'hCAFEF00D);
    chk("b2b_end_psel", bus.psel, 0);

    // Read with slave error
    set_cmd(1'b1, 1'b0, 32'h50, 32'h0, 4'hF);
    set_rsp(1'b1, 1'b1, 32'hFFFFFFFF);
    step();
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    step();
    chk("err_rsp_valid", bus.rsp_valid, 1);
    chk("err_rsp_err", bus.rsp_err, 1);
    chk("err_rsp_rdata", bus.rsp_rdata, 0);
    chk("err_rsp_timeout", bus.rsp_timeout, 0);

    // Timeout: pready never arrives
    set_cmd(1'b1, 1'b0, 32'h60, 32'h0, 4'hF);
    set_rsp(1'b0, 1'b0, 32'h99999999);
    step();
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_wait_psel", bus.psel, 1);
      chk("to_wait_penable", bus.penable, 1);
      chk("to_wait_rsp_valid", bus.rsp_valid, 0);
    end
    set_cmd(1'b1, 1'b1, 32'h70, 32'h77777777, 4'hF);
    #1;
    chk("to_abort_cmd_ready", bus.cmd_ready, 0);
    step();
    chk("to_rsp_valid", bus.rsp_valid, 1);
    chk("to_rsp_err", bus.rsp_err, 1);
    chk("to_rsp_timeout", bus.rsp_timeout, 1);
    chk("to_rsp_rdata", bus.rsp_rdata, 0);
    chk("to_psel", bus.psel, 0);
    chk("to_penable", bus.penable, 0);
    // Next command, already presented, is taken from IDLE
    set_rsp(1'b1, 1'b0, 32'h0);
    step();
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("to_next_paddr", bus.paddr, 32'h70);
    chk("to_next_psel", bus.psel, 1);
    step();
    step();
    chk("to_next_rsp_valid", bus.rsp_valid, 1);
    chk("to_next_rsp_err", bus.rsp_err, 0);
    chk("to_next_rsp_timeout", bus.rsp_timeout, 0);

    // pready on the edge the counter reaches the limit: normal completion
    set_cmd(1'b1, 1'b0, 32'h64, 32'h0, 4'hF);
    set_rsp(1'b0, 1'b0, 32'h0);
    step();
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    for (int i = 0; i < 4; i++) step();
    set_rsp(1'b1, 1'b0, 32'hA5A5A5A5);
    step();
    chk("lim_rsp_valid", bus.rsp_valid, 1);
    chk("lim_rsp_timeout", bus.rsp_timeout, 0);
    chk("lim_rsp_err", bus.rsp_err, 0);
    chk("lim_rsp_rdata", bus.rsp_rdata, 32'hA5A5A5A5);

    // Reset during ACCESS
    set_cmd(1'b1, 1'b1, 32'h80, 32'h88888888, 4'hF);
    set_rsp(1'b0, 1'b0, 32'h0);
    step();
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    chk("rs_pre_penable", bus.penable, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_psel", bus.psel, 0);
    chk("rs_penable", bus.penable, 0);
    chk("rs_paddr", bus.paddr, 0);
    chk("rs_pwdata", bus.pwdata, 0);
    chk("rs_pwrite", bus.pwrite, 0);
    set_rsp(1'b1, 1'b0, 32'h0);
    step();
    chk("rs_held_rsp_valid", bus.rsp_valid, 0);
    rst = 1'b0;
    #1;
    chk("rs_cmd_ready", bus.cmd_ready, 1);
    set_cmd(1'b1, 1'b1, 32'h90, 32'h0000ABCD, 4'h3);
    step();
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("rs_next_paddr", bus.paddr, 32'h90);
    chk("rs_next_pstrb", bus.pstrb, 4'h3);
    step();
    step();
    chk("rs_next_rsp_valid", bus.rsp_valid, 1);
    chk("rs_next_rsp_err", bus.rsp_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
